usb_tx_fifo: RTL
================

Name: usb_tx_fifo

Overview:
- Upstream feeder for the USB transmit path; buffers 16-bit result words from the miner core.
- Presents the head word to the transmitter as first-word-fall-through data, with an empty flag and a pop strobe.
- Issues a one-cycle transmit_start when a full packet's worth of words is buffered, or when a flush is requested.
- Holds off further starts until the transmitter has drained the buffer.

Parameters:
- DEPTH, 8: number of 16-bit entries; power of two, at least 2.
- PKT_WORDS, 4: buffered word count that triggers an automatic start; 1 to DEPTH.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- n_rst  input  1  asynchronous active-low reset.
- clear  input  1  synchronous clear: empties the FIFO, returns the FSM to IDLE, clears overflow.
- write_enable  input  1  push write_data this cycle.
- write_data  input  16  word from the miner core.
- flush  input  1  request transmission of a partial packet.
- read_enable  input  1  pop strobe from the transmitter.
- tx_data  output  16  head-of-FIFO word, valid whenever transmit_empty=0.
- transmit_empty  output  1  FIFO holds zero words.
- transmit_start  output  1  one-cycle pulse telling the transmitter to begin a packet.
- full  output  1  count == DEPTH.
- count  output  $clog2(DEPTH+1)  number of stored words.
- overflow  output  1  sticky flag: a write was dropped.

Behaviour:
- Reset (n_rst=0, asynchronous):
  - Pointers=0, count=0, FSM=IDLE.
  - transmit_empty=1, full=0, transmit_start=0, overflow=0, tx_data=0.
  - Memory contents are don't-care.
- clear=1 has the same effect as reset, synchronously. It takes priority over write, read and flush in that cycle.
- Storage:
  - Circular buffer with wr_ptr and rd_ptr, each log2(DEPTH) bits, wrapping DEPTH-1 -> 0.
  - count is tracked explicitly.
  - tx_data = mem[rd_ptr] (FWFT); drive 0 when empty.
- Push: accepted when write_enable=1 and (full=0, or a valid pop occurs in the same cycle). An accepted push writes mem[wr_ptr] and increments wr_ptr.
- Pop: valid when read_enable=1 and transmit_empty=0. A valid pop increments rd_ptr; the new head appears on tx_data the next cycle.
- Count update: +1 for push only, -1 for pop only, unchanged for push+pop.
- Simultaneous events:
  - Full, write and read together: both succeed; count stays DEPTH.
  - Empty, write and read together: the read is ignored (no underflow); the write succeeds; count becomes 1.
  - Read while empty: ignored; no flag.
- Write while full with no pop: data dropped, pointers unchanged, overflow set. overflow stays set until reset or clear.
- Start FSM:
  - IDLE: if count >= PKT_WORDS, go to START. Otherwise, if flush=1 and count > 0, go to START. flush with count=0 is ignored.
  - START: transmit_start=1 for exactly this one cycle. Unconditionally go to DRAIN next cycle.
  - DRAIN: transmit_start=0. Return to IDLE on the first cycle transmit_empty=1. Writes are still accepted during DRAIN. Any flush in DRAIN is ignored and is not queued.
- Latency:
  - A write that raises count to PKT_WORDS in cycle N gives the IDLE->START transition at edge N+1, so transmit_start is high during cycle N+1.
  - If the buffer drains in cycle M and count >= PKT_WORDS again in IDLE, the next start pulse comes no earlier than cycle M+2.
- transmit_start, full, transmit_empty and count are all registered or derived from registered state. None of them combinationally depends on the inputs.

Test Plan:
- Reset then idle: transmit_empty=1, count=0, transmit_start never pulses. Then write 0xA001..0xA003 (3 words, PKT_WORDS=4): no start pulse, count=3, tx_data=0xA001.
- Write a 4th word 0xA004: exactly one transmit_start pulse one cycle after count hits 4. Pop 4 times: tx_data sequence is A001, A002, A003, A004, then transmit_empty=1 and the FSM returns to IDLE.
- Fill 8 words, then write 0xBEEF with no read: write dropped, overflow=1, count=8. Write and read together while full: count stays 8, head advances, new word lands at the tail. clear: count=0, overflow=0.
- Write 2 words, pulse flush: one transmit_start pulse. Flush again during DRAIN: no second pulse. After drain, flush with count=0: no pulse.
- Pointer wrap: 20 interleaved write/read cycles across the DEPTH boundary; data order is preserved. Read while empty: count stays 0, no error.
- Assert n_rst mid-DRAIN with count=5: outputs immediately take reset values; after release the FIFO is empty and no spurious start occurs.

Source files
------------

// File: rtl/usb_tx_fifo.sv
// usb_tx_fifo: 16-bit first-word-fall-through buffer between the miner core
// and the USB transmitter. Raises a one-cycle transmit_start when a packet's
// worth of words is buffered (or on flush), then waits for the transmitter
// to drain the buffer before it can start again.
//
// Handshake semantics: a push is write_enable qualified by space (full=0, or
// a pop in the same cycle frees a slot); a pop is read_enable qualified by
// transmit_empty=0. Unqualified strobes have no effect, except that a push
// refused for lack of space sets the sticky overflow flag.
module usb_tx_fifo #(
  parameter int DEPTH     = 8,
  parameter int PKT_WORDS = 4
) (
  input  logic                         clk,
  input  logic                         n_rst,
  input  logic                         clear,
  input  logic                         write_enable,
  input  logic [15:0]                  write_data,
  input  logic                         flush,
  input  logic                         read_enable,
  output logic [15:0]                  tx_data,
  output logic                         transmit_empty,
  output logic                         transmit_start,
  output logic                         full,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         overflow,
  output logic [1:0]                   fsm_state
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] PKT_C   = CW'(PKT_WORDS);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic          push;
  logic          pop;

  // Flags come only from the registered count, never from the inputs.
  assign transmit_empty = (count == '0);
  assign full           = (count == DEPTH_C);
  assign transmit_start = (state == START);
  assign fsm_state      = state;

  // A pop frees a slot in the same cycle, so a full FIFO can still accept a write.
  assign pop  = read_enable && !transmit_empty;
  assign push = write_enable && (!full || pop);

  // Head word is shown directly; forced to zero while the buffer is empty.
  assign tx_data = transmit_empty ? 16'h0000 : mem[rd_ptr];

  // Storage array: no reset needed, only slots between rd_ptr and wr_ptr are ever read.
  always_ff @(posedge clk) begin
    if (push && !clear) begin
      mem[wr_ptr] <= write_data;
    end
  end

  // Pointers and occupancy; pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Sticky overflow: set whenever a write is refused, held until reset or clear.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      overflow <= 1'b0;
    end else if (clear) begin
      overflow <= 1'b0;
    end else if (write_enable && !push) begin
      overflow <= 1'b1;
    end
  end

  // Start sequencer next state: packet threshold wins, flush only counts when words exist.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (count >= PKT_C) begin
          state_nxt = START;
        end else if (flush && (count != '0)) begin
          state_nxt = START;
        end
      end
      START:   state_nxt = DRAIN;
      DRAIN: begin
        if (transmit_empty) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Start sequencer state register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= IDLE;
    end else if (clear) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

endmodule
